// File: rtl/nway_mux_pkg.sv
// Shared types for the N:1 flow-controlled mux: skid FSM states, grant mode,
// and the wrap-around increment used by the round-robin pointer.
package nway_mux_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;
   typedef enum logic {MODE_SEL, MODE_RR} mux_mode_e;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/nway_mux_pipe_rr_arbiter.sv
// Round-robin arbiter: first requesting index at or above ptr, wrapping to 0.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_any
);

   always_comb begin
      int idx;
      idx     = 0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!gnt_any && req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = SW'(idx);
         end
      end
   end

endmodule

// File: rtl/nway_mux_pipe.sv
// N:1 mux with a 2-entry skid output stage (main + skid registers).
// Define NWAY_MUX_RR_EN to build the round-robin arbiter and honour mode.
module nway_mux_pipe
   import nway_mux_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_src
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [SEL_W-1:0] main_src_q, main_src_d, skid_src_q, skid_src_d;

   logic [SEL_W-1:0] gnt;
   logic             gnt_vld;
   logic             sel_ok;
   logic [WIDTH-1:0] gnt_data;
   logic             push, pop;

   // Out-of-range selects grant nothing; gnt is clamped so the data slice stays in range.
   assign sel_ok = (int'(sel) < NUM_IN);

`ifdef NWAY_MUX_RR_EN
   mux_mode_e        mode_e;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, rr_gnt;
   logic             rr_any;

   assign mode_e = mux_mode_e'(mode);

   rr_arbiter #(.N(NUM_IN)) u_rr (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (rr_gnt),
      .gnt_any (rr_any)
   );

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      if (mode_e == MODE_RR) begin
         gnt     = rr_gnt;
         gnt_vld = rr_any;
      end else if (sel_ok) begin
         gnt     = sel;
         gnt_vld = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push && mode_e == MODE_RR) rr_ptr_d = SEL_W'(wrap_inc(int'(gnt), NUM_IN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign gnt         = sel_ok ? sel : '0;
   assign gnt_vld     = sel_ok;
`endif

   // Ready comes only from registered state, never from out_ready.
   always_comb begin
      in_ready = '0;
      if (!rst && gnt_vld && state_q != FULL) in_ready[gnt] = 1'b1;
   end

   assign push     = |(in_ready & in_valid);
   assign pop      = (state_q != EMPTY) && out_ready;
   assign gnt_data = in_data[gnt*WIDTH +: WIDTH];

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_src_d  = main_src_q;
      skid_data_d = skid_data_q;
      skid_src_d  = skid_src_q;
      unique case (state_q)
         EMPTY: if (push) begin
            state_d     = ONE;
            main_data_d = gnt_data;
            main_src_d  = gnt;
         end
         ONE: if (push && pop) begin
            main_data_d = gnt_data;
            main_src_d  = gnt;
         end else if (push) begin
            state_d     = FULL;
            skid_data_d = gnt_data;
            skid_src_d  = gnt;
         end else if (pop) begin
            state_d     = EMPTY;
         end
         FULL: if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_src_d  = skid_src_q;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_src_q  <= '0;
         skid_data_q <= '0;
         skid_src_q  <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_src_q  <= main_src_d;
         skid_data_q <= skid_data_d;
         skid_src_q  <= skid_src_d;
      end
   end

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_data_q;
   assign out_src   = main_src_q;

endmodule

// File: tb/tb_nway_mux_pipe.sv
// Directed bench for nway_mux_pipe: a 4-channel instance plus a 5-channel
// instance for out-of-range select. RR cases build only with NWAY_MUX_RR_EN.
module tb_nway_mux_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic [1:0]  sel, out_src;
   logic        mode, out_valid, out_ready;
   logic [15:0] out_data;

   logic [79:0] in_data5;
   logic [4:0]  in_valid5, in_ready5;
   logic [2:0]  sel5, out_src5;
   logic        mode5, out_valid5, out_ready5;
   logic [15:0] out_data5;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nway_mux_pipe #(.WIDTH(16), .NUM_IN(4)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_src(out_src)
   );

   nway_mux_pipe #(.WIDTH(16), .NUM_IN(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .sel(sel5), .mode(mode5), .out_data(out_data5), .out_valid(out_valid5),
      .out_ready(out_ready5), .out_src(out_src5)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_ch(input int i, input logic [15:0] d);
      in_data[i*16 +: 16] = d;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; sel = 2'd2; mode = 1'b0; out_ready = 1'b0;
      in_valid = 4'b0100;
      in_data5 = '0; in_valid5 = '0; sel5 = '0; mode5 = 1'b0; out_ready5 = 1'b0;
      #3;
      chk("rst_ovalid", 32'(out_valid), 32'h0);
      chk("rst_odata", 32'(out_data), 32'h0);
      chk("rst_osrc", 32'(out_src), 32'h0);
      chk("rst_irdy", 32'(in_ready), 32'h0);
      @(posedge clk); #2; rst = 1'b0; in_valid = '0;

      // single push, sel=2
      tick(); sel = 2'd2; out_ready = 1'b1; set_ch(2, 16'hBEEF); in_valid = 4'b0100;
      smp(); chk("t1_irdy", 32'(in_ready), 32'h4); chk("t1_nolat", 32'(out_valid), 32'h0);
      tick(); in_valid = '0;
      smp(); chk("t1_ovalid", 32'(out_valid), 32'h1);
      chk("t1_odata", 32'(out_data), 32'hBEEF); chk("t1_osrc", 32'(out_src), 32'h2);
      tick(); smp(); chk("t1_drain", 32'(out_valid), 32'h0);

      // backpressure fills main then skid
      tick(); sel = 2'd1; out_ready = 1'b0; set_ch(1, 16'h0001); in_valid = 4'b0010;
      smp(); chk("t2_rdy1", 32'(in_ready), 32'h2);
      tick(); set_ch(1, 16'h0002);
      smp(); chk("t2_rdy2", 32'(in_ready), 32'h2); chk("t2_d1", 32'(out_data), 32'h1);
      tick(); set_ch(1, 16'h0003);
      smp(); chk("t2_full", 32'(in_ready), 32'h0); chk("t2_hold", 32'(out_data), 32'h1);
      tick(); out_ready = 1'b1;
      smp(); chk("t2_nocomb", 32'(in_ready), 32'h0); chk("t2_o1", 32'(out_data), 32'h1);
      tick();
      smp(); chk("t2_o2", 32'(out_data), 32'h2); chk("t2_rdy3", 32'(in_ready), 32'h2);
      tick(); in_valid = '0;
      smp(); chk("t2_o3", 32'(out_data), 32'h3); chk("t2_v3", 32'(out_valid), 32'h1);
      tick(); smp(); chk("t2_empty", 32'(out_valid), 32'h0);

      // out-of-range select on the 5-channel instance, then the top channel
      sel5 = 3'd7; in_valid5 = 5'h1F; out_ready5 = 1'b1; in_data5[64 +: 16] = 16'h4444;
      smp(); chk("t3_irdy", 32'(in_ready5), 32'h0);
      tick(); smp(); chk("t3_novalid", 32'(out_valid5), 32'h0);
      sel5 = 3'd4;
      smp(); chk("t3_top_rdy", 32'(in_ready5), 32'h10);
      tick(); in_valid5 = '0;
      smp(); chk("t3_top_src", 32'(out_src5), 32'h4); chk("t3_top_data", 32'(out_data5), 32'h4444);

      for (int i = 0; i < 4; i++) set_ch(i, 16'(16'h10 * i));

`ifndef NWAY_MUX_RR_EN
      // mode is ignored without the arbiter
      tick(); mode = 1'b1; sel = 2'd3; in_valid = 4'b1111; out_ready = 1'b1;
      smp(); chk("t4_modeign_rdy", 32'(in_ready), 32'h8);
      tick(); in_valid = '0; mode = 1'b0;
      smp(); chk("t4_modeign_src", 32'(out_src), 32'h3);
      tick();
`else
      // round-robin across all four channels
      tick(); mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      smp(); chk("t4_rdy0", 32'(in_ready), 32'h1);
      for (int n = 0; n < 5; n++) begin
         tick();
         if (n == 4) in_valid = '0;
         smp();
         chk("t4_src", 32'(out_src), 32'(n % 4));
         chk("t4_data", 32'(out_data), 32'(16'h10 * (n % 4)));
      end
      tick();

      // move pointer to 2 by granting ch1, then alternate ch3/ch1
      in_valid = 4'b0010;
      smp(); chk("t5_rdy1", 32'(in_ready), 32'h2);
      tick(); in_valid = '0;
      smp(); chk("t5_src1", 32'(out_src), 32'h1);
      tick(); in_valid = 4'b1010;
      smp(); chk("t5_g3", 32'(in_ready), 32'h8);
      tick();
      smp(); chk("t5_s3", 32'(out_src), 32'h3); chk("t5_g1", 32'(in_ready), 32'h2);
      tick();
      smp(); chk("t5_s1", 32'(out_src), 32'h1); chk("t5_g3b", 32'(in_ready), 32'h8);
      tick(); out_ready = 1'b0;
      smp(); chk("t5_s3b", 32'(out_src), 32'h3); chk("t5_g1b", 32'(in_ready), 32'h2);
      tick();
      smp(); chk("t5_full", 32'(in_ready), 32'h0);
      tick();
      smp(); chk("t5_stall_rdy", 32'(in_ready), 32'h0); chk("t5_stall_src", 32'(out_src), 32'h3);
      tick(); out_ready = 1'b1;
      smp(); chk("t5_full2", 32'(in_ready), 32'h0);
      tick();
      smp(); chk("t5_skid_src", 32'(out_src), 32'h1); chk("t5_ptr_held", 32'(in_ready), 32'h8);
      tick(); in_valid = '0;
      smp(); chk("t5_last", 32'(out_src), 32'h3);
      tick(); mode = 1'b0;
`endif

      // async reset while FULL
      tick(); sel = 2'd0; out_ready = 1'b0; set_ch(0, 16'hA001); in_valid = 4'b0001;
      tick(); set_ch(0, 16'hA002);
      tick(); in_valid = '0;
      smp(); chk("t6_full", 32'(in_ready), 32'h0); chk("t6_valid", 32'(out_valid), 32'h1);
      #2; rst = 1'b1; #1;
      chk("t6_rst_ovalid", 32'(out_valid), 32'h0);
      chk("t6_rst_irdy", 32'(in_ready), 32'h0);
      chk("t6_rst_odata", 32'(out_data), 32'h0);
      @(posedge clk); #2; rst = 1'b0;
      set_ch(0, 16'h1234); in_valid = 4'b0001; out_ready = 1'b1;
      smp(); chk("t6_post_v0", 32'(out_valid), 32'h0); chk("t6_post_rdy", 32'(in_ready), 32'h1);
      tick(); in_valid = '0;
      smp(); chk("t6_post_v1", 32'(out_valid), 32'h1); chk("t6_post_d", 32'(out_data), 32'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
